// File: rtl/distance_display.sv
// rtl/distance_display.sv - 12-bit distance capture, sequential binary-to-BCD, 4-digit muxed 7-seg scan
// Common-anode, active-low segments {g,f,e,d,c,b,a}; an[0] drives the units digit.
module distance_display #(
  parameter int SCAN_DIV   = 50000,
  parameter bit BLANK_LEAD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] dist_in,
  input  logic        dist_valid,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int            PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          load;
  logic          step;
  logic          commit;
  logic [11:0]   shift_q;
  logic [15:0]   bcd_q;
  logic [15:0]   bcd_adj;
  logic [15:0]   disp_q;
  logic [3:0]    iter_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [3:0]    nib;
  logic [3:0]    blank;
  logic [6:0]    seg_nxt;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    bcd_adj = {add3(bcd_q[15:12]), add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (dist_valid) begin
          load      = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (iter_q == 4'd11) begin
          state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Double-dabble: adjust nibbles and shift the whole {bcd,shift} pair in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      shift_q <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      disp_q  <= '0;
    end else begin
      busy <= (state_nxt != IDLE);
      if (load) begin
        shift_q <= dist_in;
        bcd_q   <= '0;
        iter_q  <= '0;
      end else if (step) begin
        {bcd_q, shift_q} <= {bcd_adj[14:0], shift_q, 1'b0};
        iter_q           <= iter_q + 4'd1;
      end
      if (commit) begin
        disp_q <= bcd_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_q <= '0;
      idx_q   <= idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // A digit is blanked when it and every more significant digit are zero.
  always_comb begin
    blank[3] = (disp_q[15:12] == 4'd0);
    blank[2] = blank[3] && (disp_q[11:8] == 4'd0);
    blank[1] = blank[2] && (disp_q[7:4] == 4'd0);
    blank[0] = 1'b0;
    case (idx_q)
      2'd0:    nib = disp_q[3:0];
      2'd1:    nib = disp_q[7:4];
      2'd2:    nib = disp_q[11:8];
      default: nib = disp_q[15:12];
    endcase
    seg_nxt = (BLANK_LEAD && blank[idx_q]) ? 7'b1111111 : seg_code(nib);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1110;
      seg <= 7'b1000000;
    end else begin
      an  <= ~(4'b0001 << idx_q);
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_distance_display.sv
// tb/tb_distance_display.sv - scoreboard bench for distance_display
// Two instances: A (scan 4, blanking) for directed/random tests, B (scan 2, no blanking) for the full sweep.
module tb_distance_display;

  localparam int SD_A = 4;
  localparam int SD_B = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] din_a = '0;
  logic [11:0] din_b = '0;
  logic        val_a = 1'b0;
  logic        val_b = 1'b0;
  logic        busy_a, busy_b;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  an_a, an_b;

  distance_display #(.SCAN_DIV(SD_A), .BLANK_LEAD(1'b1)) dut_a (
    .clk(clk), .rst(rst), .dist_in(din_a), .dist_valid(val_a),
    .busy(busy_a), .seg(seg_a), .an(an_a)
  );

  distance_display #(.SCAN_DIV(SD_B), .BLANK_LEAD(1'b0)) dut_b (
    .clk(clk), .rst(rst), .dist_in(din_b), .dist_valid(val_b),
    .busy(busy_b), .seg(seg_b), .an(an_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int q_a[$];
  int q_b[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digit k of v via plain arithmetic, then the standard 7-seg glyph.
  function automatic int exp_seg(input int v, input int k, input bit bl);
    int p = 1;
    int d;
    for (int j = 0; j < k; j++) p = p * 10;
    if (bl && k > 0 && v < p) return 7'h7f;
    d = (v / p) % 10;
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic int an_index(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Monitor: each falling busy edge is a completed conversion; pop and check one full scan.
  int          prevb[2];
  int          bcnt[2];
  int          win[2];
  int          cur[2];
  logic [3:0]  seen[2];
  int          last[2];
  int          dwell[2];
  int          dwell_ok[2];
  int          sd[2] = '{SD_A, SD_B};
  bit          bl[2] = '{1'b1, 1'b0};

  always @(negedge clk) begin
    logic       b;
    logic [6:0] s;
    logic [3:0] a;
    int         idx;
    for (int i = 0; i < 2; i++) begin
      b = (i == 0) ? busy_a : busy_b;
      s = (i == 0) ? seg_a : seg_b;
      a = (i == 0) ? an_a : an_b;
      if (rst) begin
        prevb[i] = 0;
        bcnt[i]  = 0;
        win[i]   = 0;
      end else begin
        if (b === 1'b1) bcnt[i]++;
        if (prevb[i] != 0 && b === 1'b0) begin
          chk($sformatf("busy_len_%0d", i), bcnt[i], 13);
          bcnt[i] = 0;
          if ((i == 0 && q_a.size() == 0) || (i == 1 && q_b.size() == 0)) begin
            chk($sformatf("unexpected_done_%0d", i), 1, 0);
            win[i] = 0;
          end else begin
            if (i == 0) cur[i] = q_a.pop_front();
            else        cur[i] = q_b.pop_front();
            win[i]      = 4 * sd[i];
            seen[i]     = '0;
            last[i]     = -1;
            dwell[i]    = 0;
            dwell_ok[i] = 0;
          end
        end else if (win[i] > 0) begin
          idx = an_index(a);
          chk($sformatf("an_onehot_%0d an=%b", i, a), int'(idx >= 0), 1);
          if (idx >= 0) begin
            chk($sformatf("seg_%0d v=%0d digit=%0d", i, cur[i], idx),
                int'(s), exp_seg(cur[i], idx, bl[i]));
            seen[i][idx] = 1'b1;
            if (last[i] >= 0 && idx != last[i]) begin
              chk($sformatf("scan_next_%0d", i), idx, (last[i] + 1) % 4);
              if (dwell_ok[i] != 0) chk($sformatf("dwell_%0d", i), dwell[i], sd[i]);
              dwell_ok[i] = 1;
              dwell[i]    = 0;
            end
            dwell[i]++;
            last[i] = idx;
          end
          win[i]--;
          if (win[i] == 0) chk($sformatf("seen_all_%0d v=%0d", i, cur[i]), int'(seen[i]), 4'hf);
        end
        prevb[i] = (b === 1'b1) ? 1 : 0;
      end
    end
  end

  task automatic strobe_a(input int v);
    din_a = 12'(v);
    val_a = 1'b1;
    @(negedge clk);
    val_a = 1'b0;
  endtask

  task automatic strobe_b(input int v);
    din_b = 12'(v);
    val_b = 1'b1;
    @(negedge clk);
    val_b = 1'b0;
  endtask

  task automatic convert_a(input int v);
    strobe_a(v);
    q_a.push_back(v);
    repeat (32) @(negedge clk);
  endtask

  initial begin
    int v;
    int off;
    #2 rst = 1'b1;
    #1;
    chk("rst_an_a", int'(an_a), 4'b1110);
    chk("rst_seg_a", int'(seg_a), 7'b1000000);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_an_b", int'(an_b), 4'b1110);
    chk("rst_seg_b", int'(seg_b), 7'b1000000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    convert_a(99);
    convert_a(4095);

    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_an", int'(an_a), 4'b1110);
    chk("async_seg", int'(seg_a), 7'b1000000);
    chk("async_busy", int'(busy_a), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    convert_a(0);

    // 57 accepted, 300 offered while busy and dropped, 300 again on the first idle cycle.
    strobe_a(57);
    q_a.push_back(57);
    repeat (2) @(negedge clk);
    chk("busy_at_drop", int'(busy_a), 1);
    strobe_a(300);
    repeat (10) @(negedge clk);
    strobe_a(300);
    q_a.push_back(300);
    repeat (32) @(negedge clk);

    // Reset in the middle of a conversion of 1234.
    strobe_a(1234);
    repeat (5) @(negedge clk);
    chk("busy_mid_conv", int'(busy_a), 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_an", int'(an_a), 4'b1110);
    chk("abort_seg", int'(seg_a), 7'b1000000);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 4 * SD_A; n++) begin
      @(negedge clk);
      chk($sformatf("post_abort_seg digit=%0d", an_index(an_a)),
          int'(seg_a), exp_seg(0, (an_index(an_a) < 0) ? 0 : an_index(an_a), 1'b1));
    end
    convert_a(1234);

    for (int n = 0; n < 25; n++) begin
      v = int'($urandom_range(0, 4095));
      strobe_a(v);
      q_a.push_back(v);
      if ($urandom_range(0, 1) == 1) begin
        off = int'($urandom_range(1, 12));
        repeat (off - 1) @(negedge clk);
        strobe_a(int'($urandom_range(0, 4095)));
      end
      repeat (34) @(negedge clk);
    end

    // Back-to-back sweep on the unblanked instance: one strobe every 14 cycles.
    for (int n = 0; n < 4096; n++) begin
      strobe_b(n);
      q_b.push_back(n);
      repeat (13) @(negedge clk);
    end
    repeat (30) @(negedge clk);

    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
